// File: rtl/mem_cache_cmd_arbiter_rr.sv
// Round-robin N-channel command arbiter onto one memory cache port; zero-cycle accept-to-issue, in-order response routing via an ID FIFO.
// Backpressure: a stalled command parks in a hold register and blocks all channels. Optional macro: MEMARB_CH0_PRIORITY_EN.
module mem_cache_cmd_arbiter_rr #(
    parameter int NCH     = 2,
    parameter int MAX_OST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 2,
    parameter int PTE_W   = 2,
    parameter int ERRTY_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        req_valid,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH-1:0]        req_wen,
    input  logic [NCH*DATA_W-1:0] req_wdata,
    input  logic [NCH*MASK_W-1:0] req_wmask,
    input  logic [NCH*PTE_W-1:0]  req_pte,
    output logic [NCH-1:0]        resp_valid,
    output logic                  resp_error,
    output logic [ERRTY_W-1:0]    resp_errty,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [MASK_W-1:0]     mem_req_wmask,
    output logic [PTE_W-1:0]      mem_req_pte,
    input  logic                  mem_resp_valid,
    input  logic                  mem_resp_error,
    input  logic [ERRTY_W-1:0]    mem_resp_errty,
    input  logic [DATA_W-1:0]     mem_resp_rdata
);
    localparam int CH_W  = $clog2(NCH);
    localparam int FP_W  = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;
    localparam int CNT_W = $clog2(MAX_OST + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
        logic [PTE_W-1:0]  pte;
    } cmd_t;

    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             hold_vld_q, hold_vld_d;
    logic [CH_W-1:0]  hold_ch_q, hold_ch_d;
    cmd_t             hold_cmd_q, hold_cmd_d;
    logic [CH_W-1:0]  id_fifo_q [MAX_OST];
    logic [FP_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CH_W-1:0]  win_ch, push_ch, head_ch;
    cmd_t             win_cmd, out_cmd;
    logic             any_vld, can_accept, accept, push, pop;

    function automatic logic [FP_W-1:0] ptr_inc(input logic [FP_W-1:0] p);
        return (p == FP_W'(MAX_OST - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid channel at or after rr_ptr (ch0 pre-empts when prioritised).
    always_comb begin
        int idx;
        idx    = 0;
        win_ch = '0;
`ifdef MEMARB_CH0_PRIORITY_EN
        for (int k = NCH - 2; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) idx = idx - (NCH - 1);
            if (req_valid[CH_W'(idx)]) win_ch = CH_W'(idx);
        end
        if (req_valid[0]) win_ch = '0;
`else
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (req_valid[CH_W'(idx)]) win_ch = CH_W'(idx);
        end
`endif
    end

    assign win_cmd.addr  = req_addr[win_ch*ADDR_W +: ADDR_W];
    assign win_cmd.wen   = req_wen[win_ch];
    assign win_cmd.wdata = req_wdata[win_ch*DATA_W +: DATA_W];
    assign win_cmd.wmask = req_wmask[win_ch*MASK_W +: MASK_W];
    assign win_cmd.pte   = req_pte[win_ch*PTE_W +: PTE_W];

    assign any_vld    = |req_valid;
    assign can_accept = !hold_vld_q && (cnt_q < CNT_W'(MAX_OST));
    assign accept     = can_accept && any_vld;
    assign req_ready  = accept ? (NCH'(1) << win_ch) : '0;

    assign mem_req_valid = hold_vld_q || accept;
    assign out_cmd       = hold_vld_q ? hold_cmd_q : win_cmd;
    assign mem_req_addr  = out_cmd.addr;
    assign mem_req_wen   = mem_req_valid && out_cmd.wen;
    assign mem_req_wdata = out_cmd.wdata;
    assign mem_req_wmask = out_cmd.wmask;
    assign mem_req_pte   = out_cmd.pte;

    assign push    = mem_req_valid && mem_req_ready;
    assign push_ch = hold_vld_q ? hold_ch_q : win_ch;
    assign pop     = mem_resp_valid && (cnt_q != '0);
    assign head_ch = id_fifo_q[rd_ptr_q];

    assign resp_valid = pop ? (NCH'(1) << head_ch) : '0;
    assign resp_error = mem_resp_error;
    assign resp_errty = mem_resp_errty;
    assign resp_rdata = mem_resp_rdata;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        hold_vld_d = hold_vld_q;
        hold_ch_d  = hold_ch_q;
        hold_cmd_d = hold_cmd_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;
        if (accept) begin
`ifdef MEMARB_CH0_PRIORITY_EN
            if (win_ch != '0)
                rr_ptr_d = (win_ch == CH_W'(NCH - 1)) ? CH_W'(1) : win_ch + 1'b1;
`else
            rr_ptr_d = (win_ch == CH_W'(NCH - 1)) ? '0 : win_ch + 1'b1;
`endif
        end
        if (hold_vld_q && mem_req_ready) hold_vld_d = 1'b0;
        if (accept && !mem_req_ready) begin
            hold_vld_d = 1'b1;
            hold_ch_d  = win_ch;
            hold_cmd_d = win_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef MEMARB_CH0_PRIORITY_EN
            rr_ptr_q <= CH_W'(1);
`else
            rr_ptr_q <= '0;
`endif
            hold_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hold_vld_q <= hold_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Payload registers need no reset; they are qualified by hold_vld_q / cnt_q.
    always_ff @(posedge clk) begin
        hold_ch_q  <= hold_ch_d;
        hold_cmd_q <= hold_cmd_d;
        if (push) id_fifo_q[wr_ptr_q] <= push_ch;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && ($isunknown({hold_vld_q, cnt_q, rr_ptr_q}) ||
                       int'(cnt_q) > MAX_OST || int'(rr_ptr_q) >= NCH)) begin
            $display("mem_cache_cmd_arbiter_rr: illegal internal state cnt=%0d rr_ptr=%0d", cnt_q, rr_ptr_q);
            $finish;
        end
    end
`endif
endmodule

// File: tb/tb_mem_cache_cmd_arbiter_rr.sv
// Bench for mem_cache_cmd_arbiter_rr (NCH=4, MAX_OST=2): per-cycle vector table plus reset and long-stall sequences.
module tb_mem_cache_cmd_arbiter_rr;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_ready, req_wen, resp_valid;
    logic [127:0] req_addr, req_wdata;
    logic [7:0]   req_wmask, req_pte;
    logic         resp_error, mem_req_valid, mem_req_ready, mem_req_wen;
    logic [1:0]   resp_errty, mem_req_wmask, mem_req_pte, mem_resp_errty;
    logic [31:0]  resp_rdata, mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic         mem_resp_valid, mem_resp_error;

    mem_cache_cmd_arbiter_rr #(.NCH(4), .MAX_OST(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_pte(req_pte),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_errty(resp_errty), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_req_pte(mem_req_pte), .mem_resp_valid(mem_resp_valid), .mem_resp_error(mem_resp_error),
        .mem_resp_errty(mem_resp_errty), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [1:0]  wmask;
        logic [1:0]  pte;
    } tcmd_t;

    typedef struct {
        logic [3:0] v;
        logic       mrdy;
        logic       mresp;
        logic [3:0] exp_rdy;
        logic       exp_mvld;
    } vec_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    salt  = 0;
    int    exp_q[$];
    logic  hold_vld = 1'b0;
    int    hold_ch  = 0;
    tcmd_t hold_cmd;
    vec_t  tbl[22];

    function automatic tcmd_t mk_cmd(input int ch, input int s);
        tcmd_t c;
        c.addr  = 32'h100 + 32'(ch) * 32'h40 + 32'(s) * 32'h1000;
        c.wen   = (ch % 2) == 1;
        c.wdata = 32'h1234_5678 ^ (32'(ch) << 28) ^ 32'(s);
        c.wmask = 2'(ch);
        c.pte   = 2'(3 - ch);
        return c;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (salt %0d): got %h expected %h", name, salt, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic mrdy, input logic mresp);
        tcmd_t c;
        req_valid = v;
        for (int ch = 0; ch < 4; ch++) begin
            c = mk_cmd(ch, salt);
            req_addr[ch*32 +: 32]  = c.addr;
            req_wen[ch]            = c.wen;
            req_wdata[ch*32 +: 32] = c.wdata;
            req_wmask[ch*2 +: 2]   = c.wmask;
            req_pte[ch*2 +: 2]     = c.pte;
        end
        mem_req_ready  = mrdy;
        mem_resp_valid = mresp;
        mem_resp_rdata = 32'hDEAD_0000 | 32'(salt);
        mem_resp_error = salt[0];
        mem_resp_errty = 2'(salt);
    endtask

    // One clock: drive, check at the falling edge, update expectations, advance past the rising edge.
    task automatic step(input logic [3:0] v, input logic mrdy, input logic mresp,
                        input logic [3:0] exp_rdy, input logic exp_mvld);
        tcmd_t      ecmd;
        int         ch;
        logic [3:0] exp_resp;
        salt++;
        drive(v, mrdy, mresp);
        @(negedge clk);
        chk("req_ready", 128'(req_ready), 128'(exp_rdy));
        chk("mem_req_valid", 128'(mem_req_valid), 128'(exp_mvld));
        ch   = 0;
        ecmd = '0;
        if (exp_rdy != 4'b0) begin
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) ch = i;
            ecmd = mk_cmd(ch, salt);
        end else if (hold_vld) begin
            ch   = hold_ch;
            ecmd = hold_cmd;
        end
        if (exp_mvld)
            chk("mem_req_cmd", 128'({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_pte}), 128'(ecmd));
        else
            chk("mem_req_wen_idle", 128'(mem_req_wen), 128'(0));
        exp_resp = 4'b0;
        if (mresp && exp_q.size() > 0) exp_resp = 4'b1 << exp_q.pop_front();
        chk("resp_valid", 128'(resp_valid), 128'(exp_resp));
        if (exp_resp != 4'b0)
            chk("resp_fields", 128'({resp_error, resp_errty, resp_rdata}),
                128'({mem_resp_error, mem_resp_errty, mem_resp_rdata}));
        if (exp_mvld) begin
            if (mrdy) begin
                exp_q.push_back(ch);
                hold_vld = 1'b0;
            end else begin
                hold_vld = 1'b1;
                hold_ch  = ch;
                hold_cmd = ecmd;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic mresp);
        reset = 1'b1;
        drive(4'b0, 1'b0, mresp);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        hold_vld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        //          valid    mrdy  mresp exp_rdy  exp_mvld
        tbl = '{
            '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0},   // reset state
            '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1},   // all valid: 0,1,2,3,0
            '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1},
            '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1},
            '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1},
            '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1},
            '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1},   // fills to MAX_OST
            '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0},   // stalled at cnt=2
            '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0},   // pop does not free a slot this cycle
            '{4'b0101, 1'b1, 1'b1, 4'b0100, 1'b1},
            '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1},   // wrap 3 -> 0
            '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0},
            '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0},
            '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0},
            '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0},   // response with nothing outstanding
            '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1},
            '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1},   // memory stalls: capture into hold
            '{4'b1010, 1'b0, 1'b1, 4'b0000, 1'b1},
            '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1},
            '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1},   // hold drains
            '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1},
            '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0}
        };

        do_reset(1'b0);
        for (int i = 0; i < 22; i++)
            step(tbl[i].v, tbl[i].mrdy, tbl[i].mresp, tbl[i].exp_rdy, tbl[i].exp_mvld);

        // Reset with two commands outstanding; late response must be dropped, pointer back to 0.
        step(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1);
        step(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
        do_reset(1'b1);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);

        // ch1 write held for five cycles of mem_req_ready low while its inputs keep changing.
        step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1);
        repeat (4) step(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1);
        step(4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_cache_cmd_arbiter_rr.md
Name: mem_cache_cmd_arbiter_rr

Overview:
- N-channel successor to the two-port I/D memory command arbiter.
- Arbitrates CacheReq-style commands from NCH requesters onto one memory cache port using work-conserving round-robin; idle channels cost no cycles.
- Keeps up to MAX_OST commands in flight; memory responses return in order and are routed back by a channel-ID FIFO.
- Sits between the L1 caches / page-table walker and the memory-side cache.

Parameters:
- NCH, 2, number of requester channels (≥2).
- MAX_OST, 2, max accepted-but-unanswered memory commands (≥1); sets ID FIFO depth.
- ADDR_W, 32, address width.
- DATA_W, 32, wdata/rdata width.
- MASK_W, 2, wmask (MemSize) width.
- PTE_W, 2, PTE A/D field width.
- ERRTY_W, 2, error-type width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NCH  per-channel command valid
- req_ready  out  NCH  per-channel command accept
- req_addr  in  NCH*ADDR_W  per-channel address; channel i at slice i
- req_wen  in  NCH  per-channel write enable
- req_wdata  in  NCH*DATA_W  per-channel write data
- req_wmask  in  NCH*MASK_W  per-channel size
- req_pte  in  NCH*PTE_W  per-channel PTE A/D bits
- resp_valid  out  NCH  per-channel response valid
- resp_error  out  1  shared error flag
- resp_errty  out  ERRTY_W  shared error type
- resp_rdata  out  DATA_W  shared read data
- mem_req_valid / mem_req_ready  out / in  1 / 1  memory command handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_req_pte  out  ADDR_W, 1, DATA_W, MASK_W, PTE_W  memory command fields
- mem_resp_valid  in  1  memory response valid
- mem_resp_error, mem_resp_errty, mem_resp_rdata  in  1, ERRTY_W, DATA_W  memory response fields

Behaviour:
- State: rr_ptr (log2 NCH bits), hold register H (valid, ch, command), ID FIFO (MAX_OST entries, cnt).
- Winner W is the first i with req_valid[i], scanning rr_ptr, rr_ptr+1 … mod NCH.
- can_accept = !H.valid & (cnt < MAX_OST). No full-bypass: a pop in the same cycle does not free a slot.
- req_ready[i] = can_accept & any(req_valid) & (i == W). At most one bit is set. req_ready depends on other channels' valids.
- Accept cycle (valid & ready on W): the command bypasses combinationally to the mem_req_* outputs with mem_req_valid=1, giving zero-cycle latency.
  - If mem_req_ready=1 the same cycle: push W into the FIFO.
  - Otherwise: capture the command and W into H.
- While H.valid: mem_req_* = H, mem_req_valid=1, and all req_ready are 0. On mem_req_ready: push H.ch, clear H.
- When mem_req_valid=0, mem_req_* fields are don't-care; mem_req_wen is driven 0.
- rr_ptr <= (W+1) mod NCH on every accept, and only on accept.
- Response routing:
  - resp_valid[head] = mem_resp_valid & (cnt != 0); all other bits are 0.
  - Error and data fields pass through combinationally.
  - Pop on mem_resp_valid when cnt != 0.
  - mem_resp_valid with cnt==0 is a protocol violation: ignore it and assert no resp_valid.
- Push and pop in the same cycle: cnt unchanged, pointers advance with wrap-around mod MAX_OST.
- Reset (sync):
  - rr_ptr=0, H.valid=0, FIFO empty (cnt=0).
  - Outputs after reset: all resp_valid=0, mem_req_valid=0 until a req_valid arrives, req_ready per rule.
- Reset mid-operation discards H and all outstanding IDs. Late memory responses are then dropped per the cnt==0 rule.
- Unknown or illegal internal state: $display an error and $finish (simulation only).

Optional Feature:
- Macro MEMARB_CH0_PRIORITY_EN.
- Defined: channel 0 has strict priority. If req_valid[0] & can_accept, then W=0 and rr_ptr is unchanged. Channels 1..NCH-1 round-robin among themselves, with rr_ptr ranging over 1..NCH-1 and reset value 1.
- Undefined: pure round-robin over all channels as above.

Test Plan:
- NCH=2, MAX_OST=1, mem_req_ready=1: ch0 read addr 0x100, response rdata 0xDEADBEEF 3 cycles later -> mem_req_valid in the accept cycle, resp_valid=2'b01 with rdata 0xDEADBEEF, rr_ptr=1.
- NCH=4: all four channels valid continuously, memory always ready, 1-cycle response, MAX_OST=2 -> grant order 0,1,2,3,0 with no idle cycles and each response routed to its issuer.
- mem_req_ready held low 5 cycles on a ch1 write (wdata 0x12345678, wmask 2) -> command is stable from H for all 5 cycles, req_ready=0 throughout, one push when ready rises.
- MAX_OST=2: issue to ch2, then ch0, with responses delayed -> third requester stalled (req_ready=0) while cnt=2; in-order responses give resp_valid 4'b0100 then 4'b0001.
- Assert reset with cnt=2 outstanding, then mem_resp_valid=1 -> all resp_valid=0, cnt stays 0, rr_ptr=0.
- With MEMARB_CH0_PRIORITY_EN: ch0 and ch1 valid every cycle, MAX_OST=1, 1-cycle memory -> ch0 wins every accept and ch1 starves. Drop ch0 -> ch1 granted next accept.
